bdm_bit_engine: RTL and testbench

Bit-level physical engine for the single-wire BDM pin. It sits directly downstream of `bdm_interface`. It accepts byte-level operations (SYNC, WRITE, READ, WAIT) over a valid/ready handshake and drives the open-drain `bkgd` line with RS08 BDM bit timing. Read bytes come back on a held response channel. Bit timing derives from the target clock period measured during SYNC.

---
 rtl/bdm_pkg.sv | 40 ++++
 rtl/bdm_bit_engine_pin_sync.sv | 32 +++
 rtl/bdm_bit_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_bdm_bit_engine.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bdm_pkg.sv
// Shared definitions for the BDM bit engine: op-codes, FSM states and RS08 bit-timing constants.
package bdm_pkg;

    localparam logic [1:0] BDM_OP_SYNC  = 2'd0;
    localparam logic [1:0] BDM_OP_WRITE = 2'd1;
    localparam logic [1:0] BDM_OP_READ  = 2'd2;
    localparam logic [1:0] BDM_OP_WAIT  = 2'd3;

    localparam int unsigned BDM_MUL_ONE    = 4;
    localparam int unsigned BDM_MUL_SAMPLE = 10;
    localparam int unsigned BDM_MUL_ZERO   = 13;
    localparam int unsigned BDM_MUL_BIT    = 16;
    localparam int unsigned BDM_SYNC_SHIFT = 7;

    // Wide enough for 255 * 16 * 511, the longest WAIT.
    localparam int unsigned BDM_CNT_W = 21;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC_DRIVE,
        ST_SYNC_WAIT_LOW,
        ST_SYNC_MEASURE,
        ST_BIT_LOW,
        ST_BIT_REST,
        ST_WAIT_RUN,
        ST_RESP
    } bdm_state_e;

    function automatic logic [BDM_CNT_W-1:0] bdm_tc_mul(input logic [8:0] tc, input int unsigned mul);
        return BDM_CNT_W'(tc) * BDM_CNT_W'(mul);
    endfunction

    // Target cycle length from a SYNC pulse: the pulse is 128 target cycles long.
    function automatic logic [8:0] bdm_tc_from_sync(input logic [15:0] len);
        logic [15:0] q;
        q = len >> BDM_SYNC_SHIFT;
        return (q == 16'd0) ? 9'd1 : q[8:0];
    endfunction

endpackage

// File: rtl/bdm_bit_engine_pin_sync.sv
// Two-flop synchronizer for the BDM pin with single-cycle rise/fall pulses.
module bdm_pin_sync (
    input  logic clk,
    input  logic rst_in,
    input  logic pin_raw,
    output logic pin_s,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle line is pulled high, so reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pin_raw;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pin_s = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/bdm_bit_engine.sv
// RS08 BDM single-wire bit engine: SYNC/WRITE/READ/WAIT over valid/ready, open-drain bkgd.
// Optional SYNC reply timeout enabled by defining BDM_SYNC_TIMEOUT_EN.
module bdm_bit_engine
    import bdm_pkg::*;
#(
    parameter int unsigned DEFAULT_TC   = 4,
    parameter int unsigned SYNC_LOW     = 4096,
    parameter int unsigned SYNC_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic [15:0] sync_len,
    output logic [8:0]  tc,
    inout  wire         bkgd
);

    bdm_state_e           state_q;
    logic [1:0]           op_q;
    logic [BDM_CNT_W-1:0] cnt_q;
    logic [BDM_CNT_W-1:0] limit_q;
    logic [2:0]           bit_idx_q;
    logic [7:0]           shift_q;
    logic                 seen_high_q;
    logic                 drive_low_q;
    logic                 cmd_ready_q;
    logic                 rsp_valid_q;
    logic [7:0]           rsp_data_q;
    logic [15:0]          sync_len_q;
    logic [8:0]           tc_q;

    logic                 pin_s;
    logic                 pin_rise;
    logic                 pin_fall;

    logic [BDM_CNT_W-1:0] cnt_next;
    logic [BDM_CNT_W-1:0] bit_len;
    logic [BDM_CNT_W-1:0] low_len;
    logic [BDM_CNT_W-1:0] samp_idx;

    bdm_pin_sync u_pin_sync (
        .clk     (clk),
        .rst_in  (rst_in),
        .pin_raw (bkgd),
        .pin_s   (pin_s),
        .rise    (pin_rise),
        .fall    (pin_fall)
    );

    assign cnt_next = cnt_q + BDM_CNT_W'(1);
    assign bit_len  = bdm_tc_mul(tc_q, BDM_MUL_BIT);
    assign low_len  = (op_q == BDM_OP_WRITE && !shift_q[7]) ? bdm_tc_mul(tc_q, BDM_MUL_ZERO)
                                                             : bdm_tc_mul(tc_q, BDM_MUL_ONE);
    assign samp_idx = bdm_tc_mul(tc_q, BDM_MUL_SAMPLE) + BDM_CNT_W'(2);

`ifdef BDM_SYNC_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(SYNC_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;
    logic            to_hit;
    assign to_hit  = (to_cnt_q + TO_W'(1)) == TO_W'(SYNC_TIMEOUT);
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            op_q        <= BDM_OP_SYNC;
            cnt_q       <= '0;
            limit_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            seen_high_q <= 1'b0;
            drive_low_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            sync_len_q  <= '0;
            tc_q        <= 9'(DEFAULT_TC);
`ifdef BDM_SYNC_TIMEOUT_EN
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= cmd_op;
                        cnt_q       <= '0;
                        bit_idx_q   <= 3'd7;
                        shift_q     <= cmd_data;
                        unique case (cmd_op)
                            BDM_OP_SYNC: begin
                                drive_low_q <= 1'b1;
                                state_q     <= ST_SYNC_DRIVE;
                            end
                            BDM_OP_WRITE, BDM_OP_READ: begin
                                drive_low_q <= 1'b1;
                                state_q     <= ST_BIT_LOW;
                            end
                            default: begin
                                limit_q <= BDM_CNT_W'(cmd_data) * bit_len;
                                if (cmd_data == 8'd0) begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_data_q  <= '0;
                                    state_q     <= ST_RESP;
                                end else begin
                                    state_q <= ST_WAIT_RUN;
                                end
                            end
                        endcase
                    end
                end

                ST_SYNC_DRIVE: begin
                    if (cnt_next == BDM_CNT_W'(SYNC_LOW)) begin
                        drive_low_q <= 1'b0;
                        seen_high_q <= 1'b0;
                        state_q     <= ST_SYNC_WAIT_LOW;
`ifdef BDM_SYNC_TIMEOUT_EN
                        to_cnt_q    <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_next;
                    end
                end

                // The falling-edge cycle is itself the first low clock of the reply.
                ST_SYNC_WAIT_LOW: begin
                    if (pin_s)
                        seen_high_q <= 1'b1;
                    if (seen_high_q && pin_fall) begin
                        cnt_q   <= BDM_CNT_W'(1);
                        state_q <= ST_SYNC_MEASURE;
                    end
                end

                ST_SYNC_MEASURE: begin
                    if (pin_rise) begin
                        sync_len_q  <= cnt_q[15:0];
                        tc_q        <= bdm_tc_from_sync(cnt_q[15:0]);
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        state_q     <= ST_RESP;
                    end else if (cnt_q[15:0] != 16'hFFFF) begin
                        cnt_q <= cnt_next;
                    end
                end

                ST_BIT_LOW, ST_BIT_REST: begin
                    if (op_q == BDM_OP_READ && cnt_q == samp_idx)
                        shift_q <= {shift_q[6:0], pin_s};
                    if (cnt_next == bit_len) begin
                        if (bit_idx_q == 3'd0) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= (op_q == BDM_OP_READ) ? shift_q : 8'd0;
                            state_q     <= ST_RESP;
                        end else begin
                            bit_idx_q   <= bit_idx_q - 3'd1;
                            cnt_q       <= '0;
                            drive_low_q <= 1'b1;
                            state_q     <= ST_BIT_LOW;
                            if (op_q == BDM_OP_WRITE)
                                shift_q <= {shift_q[6:0], 1'b0};
                        end
                    end else begin
                        cnt_q <= cnt_next;
                        if (state_q == ST_BIT_LOW && cnt_next == low_len) begin
                            drive_low_q <= 1'b0;
                            state_q     <= ST_BIT_REST;
                        end
                    end
                end

                ST_WAIT_RUN: begin
                    if (cnt_q == limit_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_next;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
`ifdef BDM_SYNC_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                    end
                end
            endcase

`ifdef BDM_SYNC_TIMEOUT_EN
            // Timeout spans both reply phases; a completing measurement takes precedence.
            if (state_q == ST_SYNC_WAIT_LOW || (state_q == ST_SYNC_MEASURE && !pin_rise)) begin
                if (to_hit) begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= '0;
                    err_q       <= 1'b1;
                    state_q     <= ST_RESP;
                end else begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                end
            end
`endif
        end
    end

    assign bkgd      = drive_low_q ? 1'b0 : 1'bz;
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign sync_len  = sync_len_q;
    assign tc        = tc_q;

endmodule

// File: tb/tb_bdm_bit_engine.sv
// Directed self-checking bench for bdm_bit_engine with a simple open-drain target model.
module tb_bdm_bit_engine;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic        rsp_ready = 1'b0;
    logic        tgt_low = 1'b0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic [15:0] sync_len;
    logic [8:0]  tc;
    wire         bkgd;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    pullup (bkgd);
    assign bkgd = tgt_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    bdm_bit_engine #(
        .DEFAULT_TC   (4),
        .SYNC_LOW     (4096),
        .SYNC_TIMEOUT (65536)
    ) dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .sync_len  (sync_len),
        .tc        (tc),
        .bkgd      (bkgd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] data);
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic accept_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_rise"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int unsigned exp_w[8] = '{32, 104, 32, 104, 104, 32, 104, 32};
        int unsigned lows[8];
        int unsigned k;
        int unsigned bad;
        int unsigned total_low;
        logic        prev;

        // Reset
        repeat (3) tick();
        rst_in = 1'b1;
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_bkgd", 32'(bkgd), 32'd1);
        check("rst_tc", 32'(tc), 32'd4);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_sync_len", 32'(sync_len), 32'd0);

        // SYNC with a 1024-clock target reply
        issue(2'd0, 8'd0);
        check("sync_busy", 32'(cmd_ready), 32'd0);
        check("sync_first_low", 32'(bkgd), 32'd0);
        for (k = 1; k <= 5000; k++) begin
            tick();
            if (bkgd === 1'b1) break;
        end
        check("sync_drive_len", k, 32'd4096);
        repeat (5) tick();
        tgt_low = 1'b1;
        repeat (1024) tick();
        tgt_low = 1'b0;
        for (k = 1; k <= 50; k++) begin
            if (rsp_valid === 1'b1) break;
            tick();
        end
        check("sync_done", 32'(rsp_valid), 32'd1);
        check("sync_len", 32'(sync_len), 32'd1024);
        check("sync_tc", 32'(tc), 32'd8);
        check("sync_err", 32'(rsp_err), 32'd0);
        accept_rsp("sync");

        // WRITE 0xA5 at tc=8
        issue(2'd1, 8'hA5);
        for (int s = 0; s < 8; s++) lows[s] = 0;
        bad  = 0;
        prev = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            if (rsp_valid !== 1'b0) bad++;
            if (bkgd === 1'b0) begin
                lows[i / 128]++;
                if ((i % 128) != 0 && prev) bad++;
            end
            prev = (bkgd === 1'b1);
            tick();
        end
        for (int s = 0; s < 8; s++)
            check($sformatf("write_low_bit%0d", 7 - s), lows[s], exp_w[s]);
        check("write_shape", bad, 32'd0);
        check("write_rsp_valid", 32'(rsp_valid), 32'd1);
        check("write_rsp_data", 32'(rsp_data), 32'd0);
        accept_rsp("write");

        // READ: target stretches bits 7,5,3 low past the sample point
        issue(2'd2, 8'd0);
        total_low = 0;
        for (int i = 0; i < 1024; i++) begin
            tgt_low = ((i / 128) inside {0, 2, 4}) && ((i % 128) < 96);
            #1;
            if (bkgd === 1'b0) total_low++;
            @(posedge clk);
            #1;
        end
        tgt_low = 1'b0;
        check("read_low_total", total_low, 32'd448);
        check("read_rsp_valid", 32'(rsp_valid), 32'd1);
        check("read_rsp_data", 32'(rsp_data), 32'h57);
        accept_rsp("read");

        // WAIT 3 with an ignored command while busy, then backpressure
        issue(2'd3, 8'd3);
        total_low = 0;
        for (k = 1; k <= 400; k++) begin
            if (k == 10) begin
                cmd_op    = 2'd1;
                cmd_data  = 8'h00;
                cmd_valid = 1'b1;
            end
            tick();
            cmd_valid = 1'b0;
            if (bkgd === 1'b0) total_low++;
            if (rsp_valid === 1'b1) break;
        end
        check("wait_latency", k, 32'd385);
        check("wait_pin_idle", total_low, 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== 8'd0 || cmd_ready !== 1'b0 || bkgd !== 1'b1) bad++;
        end
        check("wait_backpressure", bad, 32'd0);
        accept_rsp("wait");

        // WAIT 0 responds on the acceptance edge
        issue(2'd3, 8'd0);
        check("wait0_rsp_valid", 32'(rsp_valid), 32'd1);
        accept_rsp("wait0");

        // Reset in the middle of a WRITE
        issue(2'd1, 8'h00);
        repeat (5) tick();
        check("midrst_driving", 32'(bkgd), 32'd0);
        rst_in = 1'b0;
        tick();
        check("midrst_bkgd", 32'(bkgd), 32'd1);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_tc", 32'(tc), 32'd4);
        rst_in = 1'b1;
        tick();

`ifdef BDM_SYNC_TIMEOUT_EN
        // SYNC with no target reply
        issue(2'd0, 8'd0);
        for (k = 1; k <= 70000; k++) begin
            tick();
            if (rsp_valid === 1'b1) break;
        end
        check("to_latency", k, 32'd69632);
        check("to_err", 32'(rsp_err), 32'd1);
        check("to_tc", 32'(tc), 32'd4);
        check("to_sync_len", 32'(sync_len), 32'd0);
        accept_rsp("to");
        check("to_err_clear", 32'(rsp_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
